// File: rtl/sorted_frame_uart_tx_pkg.sv
// Shared types and constants for the sorted-frame UART console dump.
// Holds the sequencer state enum, the per-byte transmitter phase and ASCII helpers.
package sorted_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_START,
        PH_DATA,
        PH_STOP
    } tx_phase_t;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;

    // Uppercase hex digit: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/sorted_frame_uart_tx_if.sv
// Bundle of the sorter stream input, the start request and the UART/status outputs.
// state exposes the sequencer FSM so checkers can follow frame progress.
interface sorted_frame_uart_tx_if
    import sorted_frame_pkg::*;
#(
    parameter int ROW_W = 4
);
    logic [7:0]       data;
    logic [ROW_W-1:0] row;
    logic             start;
    logic             tx;
    logic             busy;
    logic             done;
    logic             sorted_ok;
    state_t           state;

    // start is a level request rather than a valid/ready pair: it is sampled every
    // IDLE cycle and taken only once a full frame is captured; busy is the not-ready
    // indication, and any request seen while busy or before a full frame is dropped.
    modport master (
        output data, row, start,
        input  tx, busy, done, sorted_ok, state
    );

    modport slave (
        input  data, row, start,
        output tx, busy, done, sorted_ok, state
    );
endinterface

// File: rtl/sorted_frame_uart_tx_uart_tx_byte.sv
// 8N1 transmitter for one byte: start bit, 8 data bits LSB first, stop bit.
// byte_done is high in the last cycle of the stop bit so the caller can chain bytes.
module uart_tx_byte
    import sorted_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       load,
    output logic       tx,
    output logic       byte_done
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    tx_phase_t     r_phase;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          w_bit_end;

    assign w_bit_end = (r_baud == BAUD_MAX);
    assign byte_done = (r_phase == PH_STOP) && w_bit_end;
    assign tx        = r_tx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= PH_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else if (load) begin
            r_shift <= byte_in;
            r_tx    <= 1'b0;
            r_phase <= PH_START;
            r_baud  <= '0;
            r_bit   <= '0;
        end else if (r_phase != PH_IDLE) begin
            if (w_bit_end) begin
                r_baud <= '0;
                case (r_phase)
                    PH_START: begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_phase <= PH_DATA;
                    end
                    PH_DATA: begin
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_phase <= PH_STOP;
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                            r_bit   <= r_bit + 3'd1;
                        end
                    end
                    default: r_phase <= PH_IDLE;
                endcase
            end else begin
                r_baud <= r_baud + 1'b1;
            end
        end
    end
endmodule

// File: rtl/sorted_frame_uart_tx.sv
// Captures one frame from the sorter stream, checks it is non-decreasing and dumps it
// over UART as uppercase hex ("XX " per entry, then CR LF).
module sorted_frame_uart_tx
    import sorted_frame_pkg::*;
#(
    parameter int SIZE         = 15,
    parameter int ROW_W        = 4,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  rst,
    sorted_frame_uart_tx_if.slave bus
);
    localparam int NBYTES = 3 * SIZE + 2;
    localparam int IDX_W  = $clog2(NBYTES);
    localparam int ENT_W  = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int CNT_W  = $clog2(8 * CLKS_PER_BIT);

    localparam logic [IDX_W-1:0] IDX_CR   = IDX_W'(3 * SIZE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
    localparam logic [ENT_W-1:0] ENT_LAST = ENT_W'(SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_START_END = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_DATA_END  = CNT_W'(8 * CLKS_PER_BIT - 1);
    localparam logic [ROW_W:0]   ROW_LIMIT     = (ROW_W + 1)'(SIZE);

    logic [7:0]       r_buf [SIZE];
    logic [SIZE-1:0]  r_seen;
    state_t           r_state;
    logic [IDX_W-1:0] r_byte_idx;
    logic [ENT_W-1:0] r_entry;
    logic [1:0]       r_digit;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_sorted_ok;

    logic             w_row_ok;
    logic             w_frame_valid;
    logic             w_sorted;
    logic [7:0]       w_byte;
    logic             w_load;
    logic             w_tx;
    logic             w_byte_done;

    assign w_row_ok      = ({1'b0, bus.row} < ROW_LIMIT);
    assign w_frame_valid = &r_seen;
    assign w_load        = (r_state == LOAD);

    // Buffer writes only happen in IDLE, so the frame is frozen for the whole transmission.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && w_row_ok) begin
            r_buf[bus.row] <= bus.data;
        end
    end

    always_comb begin
        w_sorted = 1'b1;
        for (int k = 0; k < SIZE - 1; k++) begin
            if (r_buf[k] > r_buf[k+1]) begin
                w_sorted = 1'b0;
            end
        end
    end

    always_comb begin
        w_byte = SPACE;
        if (r_byte_idx == IDX_CR) begin
            w_byte = CR;
        end else if (r_byte_idx == IDX_LAST) begin
            w_byte = LF;
        end else begin
            case (r_digit)
                2'd0:    w_byte = hex_to_ascii(r_buf[r_entry][7:4]);
                2'd1:    w_byte = hex_to_ascii(r_buf[r_entry][3:0]);
                default: w_byte = SPACE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_seen      <= '0;
            r_byte_idx  <= '0;
            r_entry     <= '0;
            r_digit     <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sorted_ok <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_row_ok) begin
                        r_seen[bus.row] <= 1'b1;
                    end
                    if (bus.start && w_frame_valid) begin
                        r_state    <= LOAD;
                        r_busy     <= 1'b1;
                        r_byte_idx <= '0;
                        r_entry    <= '0;
                        r_digit    <= '0;
                    end
                end
                LOAD: begin
                    r_state <= START_BIT;
                    r_cnt   <= '0;
                end
                START_BIT: begin
                    if (r_cnt == CNT_START_END) begin
                        r_state <= DATA_BITS;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA_BITS: begin
                    if (r_cnt == CNT_DATA_END) begin
                        r_state <= STOP_BIT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP_BIT: begin
                    if (w_byte_done) begin
                        if (r_byte_idx == IDX_LAST) begin
                            r_state     <= DONE;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_sorted_ok <= w_sorted;
                        end else begin
                            r_state    <= LOAD;
                            r_byte_idx <= r_byte_idx + 1'b1;
                            if (r_digit == 2'd2) begin
                                r_digit <= 2'd0;
                                // Entry index parks on the last entry while CR/LF go out.
                                if (r_entry != ENT_LAST) begin
                                    r_entry <= r_entry + 1'b1;
                                end
                            end else begin
                                r_digit <= r_digit + 2'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_seen  <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk      (clk),
        .rst      (rst),
        .byte_in  (w_byte),
        .load     (w_load),
        .tx       (w_tx),
        .byte_done(w_byte_done)
    );

    assign bus.tx        = w_tx;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.sorted_ok = r_sorted_ok;
    assign bus.state     = r_state;
endmodule

// File: tb/tb_sorted_frame_uart_tx.sv
// Bench for sorted_frame_uart_tx: table of frames with hand-written expected console text,
// plus directed sequences for start gating, held start and reset mid-frame.
module tb_sorted_frame_uart_tx;
    import sorted_frame_pkg::*;

    localparam int SIZE      = 15;
    localparam int ROW_W     = 4;
    localparam int CPB       = 4;
    localparam int NBYTES    = 3 * SIZE + 2;
    localparam int FRAME_CYC = NBYTES * (10 * CPB + 1);
    localparam int NV        = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sorted_frame_uart_tx_if #(.ROW_W(ROW_W)) bus();

    sorted_frame_uart_tx #(
        .SIZE(SIZE),
        .ROW_W(ROW_W),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string                 name;
        logic [SIZE-1:0][7:0]  d;
        string                 exp_text;
        logic                  exp_sorted;
        logic                  hold_start;
    } frame_vec_t;

    frame_vec_t vecs [NV];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_sorted_q = 1'b0;

    logic [7:0] rx_q [$];
    logic [7:0] rx_byte;
    logic       rx_prev = 1'b1;
    int         rx_frame_err = 0;
    int         done_cnt = 0;

    // UART receiver: detect falling edge, sample each bit at its middle.
    always begin
        @(negedge clk);
        if (rx_prev === 1'b1 && bus.tx === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            if (bus.tx !== 1'b0) rx_frame_err++;
            for (int j = 0; j < 8; j++) begin
                repeat (CPB) @(negedge clk);
                rx_byte[j] = bus.tx;
            end
            repeat (CPB) @(negedge clk);
            if (bus.tx !== 1'b1) rx_frame_err++;
            rx_q.push_back(rx_byte);
        end
        rx_prev = bus.tx;
    end

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic string str_rep(input string s, input int n);
        string r;
        r = "";
        for (int i = 0; i < n; i++) r = {r, s};
        return r;
    endfunction

    task automatic capture(input logic [SIZE-1:0][7:0] d, input int nrows);
        for (int k = 0; k < nrows; k++) begin
            @(negedge clk);
            bus.row  = ROW_W'(k);
            bus.data = d[k];
            @(negedge clk);
            bus.row  = 4'hF;
            bus.data = 8'hAA;
        end
        @(negedge clk);
        bus.row  = 4'hF;
        bus.data = 8'h00;
    endtask

    task automatic run_frame(input frame_vec_t v);
        int   base_rx;
        int   base_err;
        int   base_done;
        int   cycles;
        int   busy_bad;
        int   idle_bad;
        int   mism;
        int   aa_seen;
        int   nrx;
        logic got_done;
        @(negedge clk);
        check({v.name, "/sorted_ok_hold"}, 32'(bus.sorted_ok), 32'(exp_sorted_q));
        base_rx   = rx_q.size();
        base_err  = rx_frame_err;
        base_done = done_cnt;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        check({v.name, "/busy_after_accept"}, 32'(bus.busy), 32'd1);
        check({v.name, "/tx_idle_at_accept"}, 32'(bus.tx), 32'd1);
        if (!v.hold_start) bus.start = 1'b0;
        cycles   = 0;
        busy_bad = 0;
        got_done = 1'b0;
        while (cycles < 4000 && !got_done) begin
            @(posedge clk);
            cycles++;
            #1;
            if (cycles == 1) check({v.name, "/first_start_bit"}, 32'(bus.tx), 32'd0);
            if (bus.done === 1'b1) got_done = 1'b1;
            else if (bus.busy !== 1'b1) busy_bad++;
        end
        check({v.name, "/done_seen"}, 32'(got_done), 32'd1);
        check({v.name, "/frame_cycles"}, 32'(cycles), 32'(FRAME_CYC));
        check({v.name, "/busy_gaps"}, 32'(busy_bad), 32'd0);
        check({v.name, "/busy_in_done"}, 32'(bus.busy), 32'd0);
        check({v.name, "/sorted_ok"}, 32'(bus.sorted_ok), 32'(v.exp_sorted));
        exp_sorted_q = v.exp_sorted;
        @(posedge clk);
        #1;
        check({v.name, "/done_one_cycle"}, 32'(bus.done), 32'd0);
        check({v.name, "/state_idle"}, 32'(bus.state), 32'(IDLE));
        idle_bad = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) idle_bad++;
        end
        check({v.name, "/no_second_frame"}, 32'(idle_bad), 32'd0);
        bus.start = 1'b0;
        check({v.name, "/done_pulses"}, 32'(done_cnt - base_done), 32'd1);
        nrx = rx_q.size() - base_rx;
        check({v.name, "/rx_len"}, 32'(nrx), 32'(NBYTES));
        mism    = 0;
        aa_seen = 0;
        for (int i = 0; i < nrx && i < NBYTES; i++) begin
            if (rx_q[base_rx+i] !== v.exp_text.getc(i)) mism++;
            if (rx_q[base_rx+i] === 8'hAA) aa_seen++;
        end
        check({v.name, "/rx_bytes"}, 32'(mism), 32'd0);
        check({v.name, "/rx_no_aa"}, 32'(aa_seen), 32'd0);
        check({v.name, "/rx_framing"}, 32'(rx_frame_err - base_err), 32'd0);
    endtask

    initial begin
        logic [7:0] mixed [SIZE];
        int bad;
        mixed = '{8'h00, 8'h1A, 8'h2B, 8'h3C, 8'h4D, 8'h5E, 8'h6F, 8'h70,
                  8'h81, 8'h92, 8'hA3, 8'hB4, 8'hC5, 8'hD6, 8'hE7};

        vecs[0].name = "ascending";
        for (int k = 0; k < SIZE; k++) vecs[0].d[k] = 8'(k + 1);
        vecs[0].exp_text   = "01 02 03 04 05 06 07 08 09 0A 0B 0C 0D 0E 0F \r\n";
        vecs[0].exp_sorted = 1'b1;
        vecs[0].hold_start = 1'b0;

        vecs[1] = vecs[0];
        vecs[1].name = "swap_3_4";
        vecs[1].d[3] = 8'h05;
        vecs[1].d[4] = 8'h04;
        vecs[1].exp_text   = "01 02 03 05 04 06 07 08 09 0A 0B 0C 0D 0E 0F \r\n";
        vecs[1].exp_sorted = 1'b0;

        vecs[2].name = "drop_at_0";
        for (int k = 0; k < SIZE; k++) vecs[2].d[k] = 8'h7F;
        vecs[2].d[0] = 8'h80;
        vecs[2].exp_text   = {"80 ", str_rep("7F ", 14), "\r\n"};
        vecs[2].exp_sorted = 1'b0;
        vecs[2].hold_start = 1'b0;

        vecs[3].name = "drop_at_13";
        for (int k = 0; k < SIZE; k++) vecs[3].d[k] = 8'h10;
        vecs[3].d[14] = 8'h0F;
        vecs[3].exp_text   = {str_rep("10 ", 14), "0F \r\n"};
        vecs[3].exp_sorted = 1'b0;
        vecs[3].hold_start = 1'b0;

        vecs[4].name = "all_ff_held_start";
        for (int k = 0; k < SIZE; k++) vecs[4].d[k] = 8'hFF;
        vecs[4].exp_text   = {str_rep("FF ", 15), "\r\n"};
        vecs[4].exp_sorted = 1'b1;
        vecs[4].hold_start = 1'b1;

        vecs[5].name = "hex_letters";
        for (int k = 0; k < SIZE; k++) vecs[5].d[k] = mixed[k];
        vecs[5].exp_text   = "00 1A 2B 3C 4D 5E 6F 70 81 92 A3 B4 C5 D6 E7 \r\n";
        vecs[5].exp_sorted = 1'b1;
        vecs[5].hold_start = 1'b0;

        bus.start = 1'b0;
        bus.row   = 4'hF;
        bus.data  = 8'h00;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset/tx", 32'(bus.tx), 32'd1);
        check("reset/busy", 32'(bus.busy), 32'd0);
        check("reset/done", 32'(bus.done), 32'd0);
        check("reset/sorted_ok", 32'(bus.sorted_ok), 32'd0);
        check("reset/state", 32'(bus.state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;

        // Partial frame: start must be dropped.
        capture(vecs[0].d, 10);
        bus.start = 1'b1;
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.busy !== 1'b0 || bus.tx !== 1'b1) bad++;
        end
        bus.start = 1'b0;
        check("gate_partial/ignored", 32'(bad), 32'd0);
        check("gate_partial/state", 32'(bus.state), 32'(IDLE));

        for (int i = 0; i < NV; i++) begin
            capture(vecs[i].d, SIZE);
            run_frame(vecs[i]);
        end

        // Reset while byte 10 is in its data bits.
        capture(vecs[0].d, SIZE);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (421) @(posedge clk);
        #1;
        check("reset_mid/at_data_bits", 32'(bus.state), 32'(DATA_BITS));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_mid/tx", 32'(bus.tx), 32'd1);
        check("reset_mid/busy", 32'(bus.busy), 32'd0);
        check("reset_mid/done", 32'(bus.done), 32'd0);
        check("reset_mid/sorted_ok", 32'(bus.sorted_ok), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_sorted_q = 1'b0;
        bus.start = 1'b1;
        bad = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.busy !== 1'b0 || bus.tx !== 1'b1) bad++;
        end
        bus.start = 1'b0;
        check("reset_mid/start_without_capture", 32'(bad), 32'd0);
        repeat (50) @(posedge clk);

        capture(vecs[0].d, SIZE);
        run_frame(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
